mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter that shares one single-port, 1-cycle-read-latency memory between the core's instruction-fetch port and its load/store port. Sits between the single-cycle core's fetch/LSU interfaces and a unified instruction/data memory. Issues at most one memory access per cycle, tracks the owner of the in-flight read and returns read data to that owner. Prevents fetch starvation.

## Interface
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- MAX_WAIT, 4, max consecutive cycles fetch may lose arbitration (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DW  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = write
- d_be  in  DW/8  write byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid (reads only)
- d_rdata  out  DW  load data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_be  out  DW/8  memory byte enables
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid cycle after mem_en && !mem_we

## Operation
- Grant is combinational in the request cycle; request fields must stay stable while req=1 and gnt=0.
- Only one of if_gnt/d_gnt high per cycle; mem_en = if_gnt | d_gnt.
- Only fetch requesting → fetch granted; only data → data granted; neither → mem_en=0, mem_* = 0.
- Both requesting (conflict): data wins unless wait_cnt == MAX_WAIT, then fetch wins.
- wait_cnt: register, width clog2(MAX_WAIT+1); +1 each cycle if_req && !if_gnt, saturating at MAX_WAIT; cleared when if_gnt or !if_req.
- Fetch grant drives mem_we=0, mem_be=all-ones, mem_addr=if_addr, mem_wdata=0.
- Data grant drives mem_we=d_we, mem_be = d_we ? d_be : all-ones, mem_addr=d_addr, mem_wdata=d_wdata.
- Owner register: rd_pend (1b), rd_owner (0=fetch,1=data), loaded each cycle from the grant: rd_pend = mem_en && !mem_we.
- if_rvalid = rd_pend && !rd_owner; d_rvalid = rd_pend && rd_owner.
- x_rdata = mem_rdata when x_rvalid, else 0.
- Writes produce no rvalid; d_gnt is completion for writes.

## Timing
- Reset: wait_cnt=0, rd_pend=0, rd_owner=0; hence if_rvalid=d_rvalid=0, if_rdata=d_rdata=0. Combinational outputs follow inputs during reset, except that if_gnt, d_gnt and mem_en are forced to 0 while rst=1.
- Read latency: gnt at cycle t → rvalid at t+1. Fully pipelined: a new grant is allowed at t+1 concurrently with the t+1 return.
- Write: committed at the grant edge; zero return cycles.
- Conflict throughput: fetch waits at most MAX_WAIT cycles; at MAX_WAIT=4 the grant pattern under continuous conflict is D,D,D,D,F repeating.
- Reset asserted mid-read: pending rvalid dropped immediately (async), never delivered after release.
- First cycle after reset release: arbitration normal, wait_cnt=0.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on conflict, grant goes to the requester not granted in the most recent conflict cycle. A last_conflict_winner register, reset to fetch, selects the winner, so the first conflict goes to data. wait_cnt and MAX_WAIT are unused.
- Undefined: fixed data priority with the MAX_WAIT starvation guard above.

## Test plan
- Reset held, both req=1 → all gnt/rvalid/mem_en 0, rdata 0; release → fetch and data serviced normally.
- Fetch only at addr 0x10, mem returns 0xDEADBEEF → if_gnt at t, if_rvalid=1 and if_rdata=0xDEADBEEF at t+1, d_rvalid=0.
- Data write addr 0x40, be=4'b0011, wdata 0x1234 → d_gnt, mem_we=1, mem_be=0011, no rvalid next cycle.
- Continuous conflict, 10 cycles, MAX_WAIT=4 → grants D,D,D,D,F,D,D,D,D,F (round-robin build: D,F,D,F,…).
- Back-to-back reads F at t, D at t+1 → if_rvalid at t+1, d_rvalid at t+2, each carrying its own mem_rdata.
- rst pulsed one cycle after a data read grant → d_rvalid stays 0, wait_cnt=0 afterwards.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, 1-cycle-read-latency memory between the fetch port
// and the load/store port. Only one access is issued per cycle. The owner of
// each in-flight read is registered so the read data goes back to that port.
// Conflict policy:
//   default                  - data has priority. A saturating wait counter
//                              forces a fetch grant after MAX_WAIT lost cycles.
//   ARB_ROUND_ROBIN_EN       - on a conflict, the port that did not win the
//                              previous conflict wins this one.
module mem_port_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   // fetch port
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [DW-1:0]   if_rdata,
   // load/store port
   input  logic            d_req,
   input  logic            d_we,
   input  logic [DW/8-1:0] d_be,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   // memory port
   output logic            mem_en,
   output logic            mem_we,
   output logic [DW/8-1:0] mem_be,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata
);

   localparam int BW = DW / 8;

   logic w_conflict;
   logic w_fetch_wins;   // fetch takes a conflict cycle
   logic w_if_sel;       // arbitration result before reset gating
   logic w_d_sel;

   logic r_rd_pend;      // a read was issued last cycle
   logic r_rd_owner;     // 0 = fetch, 1 = data

   assign w_conflict = if_req & d_req;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last_winner;  // 0 = fetch, 1 = data; winner of the latest conflict

   assign w_fetch_wins = r_last_winner;

   // Remember who won the most recent conflict so the other side wins next time
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_winner <= 1'b0;
      end else if (w_conflict) begin
         r_last_winner <= ~w_fetch_wins;
      end
   end
`else
   localparam int WCW = $clog2(MAX_WAIT + 1);

   logic [WCW-1:0] r_wait_cnt;  // consecutive cycles fetch requested but lost

   assign w_fetch_wins = (r_wait_cnt == WCW'(MAX_WAIT));

   // Count lost fetch cycles and saturate; clear once fetch is served or idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (if_req && !if_gnt) begin
         if (r_wait_cnt != WCW'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
      end else begin
         r_wait_cnt <= '0;
      end
   end
`endif

   // The memory-side mux follows the raw selection so its fields track the
   // inputs even during reset; only the handshakes are gated by reset.
   assign w_if_sel = if_req & (~d_req | w_fetch_wins);
   assign w_d_sel  = d_req & ~w_if_sel;

   assign if_gnt = w_if_sel & ~rst;
   assign d_gnt  = w_d_sel & ~rst;
   assign mem_en = if_gnt | d_gnt;

   // Route the selected requester onto the memory port, all zeros when idle
   always_comb begin
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_if_sel) begin
         mem_be   = {BW{1'b1}};
         mem_addr = if_addr;
      end else if (w_d_sel) begin
         mem_we    = d_we;
         mem_be    = d_we ? d_be : {BW{1'b1}};
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
   end

   // Track the owner of the read issued this cycle; its data returns next cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_pend  <= 1'b0;
         r_rd_owner <= 1'b0;
      end else begin
         r_rd_pend  <= mem_en & ~mem_we;
         r_rd_owner <= d_gnt;
      end
   end

   assign if_rvalid = r_rd_pend & ~r_rd_owner;
   assign d_rvalid  = r_rd_pend & r_rd_owner;
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (AW=32, DW=32, MAX_WAIT=4).
// Inputs change 1 time unit after the rising edge. Outputs are sampled a
// little later in the same cycle.
module tb_mem_port_arbiter;
   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance to 1 time unit after the next rising edge
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
      next_cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      if_req = 1'b0; d_req = 1'b0;
      next_cycle();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
      mem_rdata = 32'hA5A5A5A5;
      next_cycle();
      #1;
      checks++;
      if ({if_gnt, d_gnt, mem_en} !== 3'b000) begin
         errors++;
         $display("FAIL reset_gnt: got if/d/en=%b required 000", {if_gnt, d_gnt, mem_en});
      end
      checks++;
      if ({if_rvalid, d_rvalid} !== 2'b00 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rvalid: got rv=%b if_rdata=%h d_rdata=%h required 00/0/0",
                  {if_rvalid, d_rvalid}, if_rdata, d_rdata);
      end
      $display("reset held: if_gnt=%b d_gnt=%b mem_en=%b", if_gnt, d_gnt, mem_en);
      rst = 1'b0;
      #1;
      checks++;
      if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h24) begin
         errors++;
         $display("FAIL reset_release_data: got d_gnt=%b if_gnt=%b addr=%h required 1/0/00000024",
                  d_gnt, if_gnt, mem_addr);
      end
      next_cycle();
      d_req = 1'b0;
      #1;
      checks++;
      if (if_gnt !== 1'b1 || d_rvalid !== 1'b1 || mem_addr !== 32'h20) begin
         errors++;
         $display("FAIL reset_release_fetch: got if_gnt=%b d_rvalid=%b addr=%h required 1/1/00000020",
                  if_gnt, d_rvalid, mem_addr);
      end
      $display("after release: data then fetch serviced");
      idle();
   endtask

   task automatic test_fetch_read();
      if_req = 1'b1; if_addr = 32'h10;
      #1;
      checks++;
      if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 ||
          mem_be !== 4'hF || mem_addr !== 32'h10 || mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL fetch_issue: got gnt=%b%b en=%b we=%b be=%h addr=%h wd=%h required 10/1/0/f/00000010/0",
                  if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
      end
      next_cycle();
      if_req = 1'b0;
      mem_rdata = 32'hDEADBEEF;
      #1;
      checks++;
      if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
         errors++;
         $display("FAIL fetch_return: got if_rv=%b if_rdata=%h d_rv=%b d_rdata=%h required 1/deadbeef/0/0",
                  if_rvalid, if_rdata, d_rvalid, d_rdata);
      end
      $display("fetch read 0x10: if_rdata=%h", if_rdata);
      idle();
   endtask

   task automatic test_data_write();
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h40; d_wdata = 32'h1234;
      #1;
      checks++;
      if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
          mem_be !== 4'b0011 || mem_addr !== 32'h40 || mem_wdata !== 32'h1234) begin
         errors++;
         $display("FAIL write_issue: got gnt=%b%b en=%b we=%b be=%b addr=%h wd=%h required 01/1/1/0011/00000040/00001234",
                  if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
      end
      next_cycle();
      d_req = 1'b0; d_we = 1'b0;
      mem_rdata = 32'hCAFEF00D;
      #1;
      checks++;
      if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || d_rdata !== 32'h0 || if_rdata !== 32'h0) begin
         errors++;
         $display("FAIL write_no_rvalid: got d_rv=%b if_rv=%b d_rdata=%h if_rdata=%h required 0/0/0/0",
                  d_rvalid, if_rvalid, d_rdata, if_rdata);
      end
      $display("data write 0x40 be=0011: no read return");
      idle();
   endtask

   task automatic test_conflict();
      logic [9:0] exp_f;
`ifdef ARB_ROUND_ROBIN_EN
      exp_f = 10'b1010101010;   // bit i = 1 means fetch wins cycle i
`else
      exp_f = 10'b1000010000;
`endif
      do_reset();
      if_req = 1'b1; if_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      for (int i = 0; i < 10; i++) begin
         mem_rdata = 32'h5000 + i;
         #1;
         checks++;
         if (if_gnt !== exp_f[i] || d_gnt !== ~exp_f[i]) begin
            errors++;
            $display("FAIL conflict_gnt[%0d]: got if_gnt=%b d_gnt=%b required %b/%b",
                     i, if_gnt, d_gnt, exp_f[i], ~exp_f[i]);
         end
         if (i > 0) begin
            checks++;
            if (if_rvalid !== exp_f[i-1] || d_rvalid !== ~exp_f[i-1] ||
                (exp_f[i-1] ? if_rdata : d_rdata) !== 32'h5000 + i) begin
               errors++;
               $display("FAIL conflict_ret[%0d]: got if_rv=%b d_rv=%b if_rd=%h d_rd=%h required if_rv=%b data=%h",
                        i, if_rvalid, d_rvalid, if_rdata, d_rdata, exp_f[i-1], 32'h5000 + i);
            end
         end
         $display("conflict cycle %0d: grant %s", i, if_gnt ? "F" : "D");
         next_cycle();
      end
      idle();
   endtask

   task automatic test_back_to_back();
      if_req = 1'b1; if_addr = 32'h100;
      #1;
      checks++;
      if (if_gnt !== 1'b1) begin
         errors++;
         $display("FAIL b2b_fetch_gnt: got %b required 1", if_gnt);
      end
      next_cycle();
      if_req = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      mem_rdata = 32'h11111111;
      #1;
      checks++;
      if (if_rvalid !== 1'b1 || if_rdata !== 32'h11111111 || d_rvalid !== 1'b0 ||
          d_gnt !== 1'b1 || mem_addr !== 32'h200) begin
         errors++;
         $display("FAIL b2b_t1: got if_rv=%b if_rd=%h d_rv=%b d_gnt=%b addr=%h required 1/11111111/0/1/00000200",
                  if_rvalid, if_rdata, d_rvalid, d_gnt, mem_addr);
      end
      next_cycle();
      d_req = 1'b0;
      mem_rdata = 32'h22222222;
      #1;
      checks++;
      if (d_rvalid !== 1'b1 || d_rdata !== 32'h22222222 || if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
         errors++;
         $display("FAIL b2b_t2: got d_rv=%b d_rd=%h if_rv=%b if_rd=%h required 1/22222222/0/0",
                  d_rvalid, d_rdata, if_rvalid, if_rdata);
      end
      $display("back-to-back F then D: returns %h / %h", 32'h11111111, d_rdata);
      idle();
   endtask

   task automatic test_reset_mid_read();
      // four conflict cycles push the starvation counter to its limit
      if_req = 1'b1; if_addr = 32'h300;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h304;
      for (int i = 0; i < 4; i++) next_cycle();
      if_req = 1'b0; d_req = 1'b0;
      mem_rdata = 32'h33333333;
      #1;
      checks++;
      if ((if_rvalid | d_rvalid) !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pending: got if_rv=%b d_rv=%b required one set", if_rvalid, d_rvalid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
         errors++;
         $display("FAIL midrst_drop: got if_rv=%b d_rv=%b d_rd=%h required 0/0/0",
                  if_rvalid, d_rvalid, d_rdata);
      end
      next_cycle();
      rst = 1'b0;
      if_req = 1'b1; d_req = 1'b1;
      #1;
      checks++;
      if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_after: got if_rv=%b d_rv=%b required 0/0", if_rvalid, d_rvalid);
      end
      checks++;
      if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
         errors++;
         $display("FAIL midrst_arb_cleared: got d_gnt=%b if_gnt=%b required 1/0", d_gnt, if_gnt);
      end
      $display("reset mid-read: pending return dropped, arbitration restarted");
      idle();
   endtask

   initial begin
      rst = 1'b1;
      if_req = 1'b0; if_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
      mem_rdata = 32'h0;
      test_reset();
      test_fetch_read();
      test_data_write();
      test_conflict();
      test_back_to_back();
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
